riscv_fetch_unit: RTL and testbench

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: PC register, request/response handshake to instruction memory, instruction register.
// Optional macro RISCV_MISALIGN_TRAP_EN: a misaligned next PC traps instead of being realigned.
module riscv_fetch_unit #(
  parameter int                 BW_DATA   = 32,
  parameter logic [BW_DATA-1:0] RESET_PC  = 'h0000_0000,
  parameter logic [BW_DATA-1:0] NOP_INSTR = 'h0000_0013
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fetch,
  input  logic               i_flush,
  output logic               o_imem_req,
  output logic [BW_DATA-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [BW_DATA-1:0] i_imem_rdata,
  input  logic               i_pc_we,
  input  logic [1:0]         i_pc_sel,
  input  logic [BW_DATA-1:0] i_alu_result,
  input  logic [BW_DATA-1:0] i_alu_out,
  output logic [BW_DATA-1:0] o_pc,
  output logic [BW_DATA-1:0] o_pc_old,
  output logic [BW_DATA-1:0] o_instr,
  output logic               o_instr_valid,
  output logic               o_trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BW_DATA-1:0] pc_q, pc_d;
  logic [BW_DATA-1:0] pc_old_q, pc_old_d;
  logic [BW_DATA-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic [BW_DATA-1:0] pc_next;
`ifdef RISCV_MISALIGN_TRAP_EN
  logic               trap_q, trap_d;
`endif

  always_comb begin
    pc_next = pc_q;
    case (i_pc_sel)
      2'b00:   pc_next = pc_q + BW_DATA'(4);
      2'b01:   pc_next = i_alu_result;
      2'b10:   pc_next = i_alu_out;
      default: pc_next = pc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_old_d = pc_old_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
`ifdef RISCV_MISALIGN_TRAP_EN
    trap_d   = 1'b0;
`endif

    // A set drop flag swallows exactly one response, whatever the state.
    if (drop_q && i_imem_rvalid) begin
      drop_d = 1'b0;
    end

    if (i_flush) begin
      state_d = IDLE;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      // The outstanding response is still due unless it is arriving right now.
      if (state_q == RESP) begin
        drop_d = drop_q | ~i_imem_rvalid;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_fetch) state_d = REQ;
        end
        REQ: begin
          if (i_imem_gnt) state_d = RESP;
        end
        RESP: begin
          if (i_imem_rvalid && !drop_q) begin
            instr_d  = i_imem_rdata;
            pc_old_d = pc_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (i_pc_we) begin
            valid_d = 1'b0;
            state_d = IDLE;
`ifdef RISCV_MISALIGN_TRAP_EN
            if (pc_next[1:0] != 2'b00) begin
              trap_d = 1'b1;
            end else begin
              pc_d = pc_next;
            end
`else
            pc_d = pc_next & ~BW_DATA'(3);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_old_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_old_q <= pc_old_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

`ifdef RISCV_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end
  assign o_trap = trap_q;
`else
  assign o_trap = 1'b0;
`endif

  assign o_imem_req    = (state_q == REQ);
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_pc_old      = pc_old_q;
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed self-checking bench for riscv_fetch_unit; one task per scenario, one line per transaction.
module tb_riscv_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch = 1'b0, flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        pc_we = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] alu_result = '0, alu_out = '0;
  logic [31:0] pc, pc_old, instr;
  logic        instr_valid, trap;

  int checks = 0;
  int failures = 0;

  riscv_fetch_unit dut (
    .i_clk(clk), .i_rst(rst), .i_fetch(fetch), .i_flush(flush),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_pc_we(pc_we), .i_pc_sel(pc_sel), .i_alu_result(alu_result), .i_alu_out(alu_out),
    .o_pc(pc), .o_pc_old(pc_old), .o_instr(instr), .o_instr_valid(instr_valid), .o_trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> REQ -> RESP -> HOLD with immediate grant and a one-cycle response.
  task automatic do_fetch(input logic [31:0] data);
    fetch = 1'b1; step(); fetch = 1'b0;
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = data; step(); imem_rvalid = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] sel, input logic [31:0] res, input logic [31:0] out);
    pc_sel = sel; alu_result = res; alu_out = out; pc_we = 1'b1;
    step();
    pc_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || pc_old !== 32'h0 || instr !== NOP || instr_valid !== 1'b0 || trap !== 1'b0) begin
      failures++;
      $display("FAIL reset: req=%b pc=%h pc_old=%h instr=%h valid=%b trap=%b, required 0/0/0/%h/0/0",
               imem_req, pc, pc_old, instr, instr_valid, trap, NOP);
    end
    step(); step();
    rst = 1'b0; step();
    $display("test_reset: pc=%h instr=%h", pc, instr);
  endtask

  task automatic test_basic_fetch();
    fetch = 1'b1; step(); fetch = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL req_issue: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr !== 32'h0050_0093 || pc_old !== 32'h0 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL capture: instr=%h pc_old=%h valid=%b, required 00500093/00000000/1", instr, pc_old, instr_valid);
    end
    step();
    checks++;
    if (instr !== 32'h0050_0093 || instr_valid !== 1'b1 || pc !== 32'h0) begin
      failures++;
      $display("FAIL hold_stable: instr=%h valid=%b pc=%h, required 00500093/1/00000000", instr, instr_valid, pc);
    end
    do_commit(2'b00, 32'h0, 32'h0);
    checks++;
    if (pc !== 32'h4 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL commit_pc4: pc=%h valid=%b, required 00000004/0", pc, instr_valid);
    end
    $display("test_basic_fetch: instr=%h pc=%h", instr, pc);
  endtask

  task automatic test_pc_we_ignored();
    pc_we = 1'b1; pc_sel = 2'b01; alu_result = 32'h0000_0800; step(); pc_we = 1'b0;
    checks++;
    if (pc !== 32'h4) begin
      failures++;
      $display("FAIL pc_we_idle: pc=%h, required 00000004", pc);
    end
    $display("test_pc_we_ignored: pc=%h", pc);
  endtask

  task automatic test_gnt_delay();
    fetch = 1'b1; step(); fetch = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
        failures++;
        $display("FAIL gnt_wait cycle %0d: req=%b addr=%h, required 1/00000004", c, imem_req, imem_addr);
      end
      step();
    end
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL req_drop_after_gnt: req=%b, required 0", imem_req);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr !== 32'h0010_0113 || pc_old !== 32'h4 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL delayed_capture: instr=%h pc_old=%h valid=%b, required 00100113/00000004/1", instr, pc_old, instr_valid);
    end
    do_commit(2'b00, 32'h0, 32'h0);
    $display("test_gnt_delay: pc=%h", pc);
  endtask

  task automatic test_pc_sel();
    do_fetch(32'h0000_0001);
    do_commit(2'b01, 32'h0000_0100, 32'h0000_0BAD);
    checks++;
    if (pc !== 32'h100) begin
      failures++;
      $display("FAIL sel_alu_result: pc=%h, required 00000100", pc);
    end
    do_fetch(32'h0000_0002);
    do_commit(2'b11, 32'h0000_0200, 32'h0000_0300);
    checks++;
    if (pc !== 32'h100) begin
      failures++;
      $display("FAIL sel_hold: pc=%h, required 00000100", pc);
    end
    do_fetch(32'h0000_0003);
    do_commit(2'b10, 32'h0000_0200, 32'hFFFF_FFFC);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL sel_alu_out: pc=%h, required fffffffc", pc);
    end
    do_fetch(32'h0000_0004);
    checks++;
    if (pc_old !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL pc_old_top: pc_old=%h, required fffffffc", pc_old);
    end
    do_commit(2'b00, 32'h0, 32'h0);
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: pc=%h, required 00000000", pc);
    end
    $display("test_pc_sel: pc=%h", pc);
  endtask

  task automatic test_flush_resp();
    fetch = 1'b1; step(); fetch = 1'b0;
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    checks++;
    if (instr !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL flush_resp: instr=%h valid=%b req=%b pc=%h, required %h/0/0/00000000", instr, instr_valid, imem_req, pc, NOP);
    end
    fetch = 1'b1; step(); fetch = 1'b0;
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr === 32'hDEAD_BEEF || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stale_drop: instr=%h valid=%b, required not deadbeef/0", instr, instr_valid);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL after_drop: instr=%h valid=%b, required 00000013/1", instr, instr_valid);
    end
    $display("test_flush_resp: instr=%h", instr);
  endtask

  task automatic test_flush_hold();
    flush = 1'b1; pc_we = 1'b1; pc_sel = 2'b00; step(); flush = 1'b0; pc_we = 1'b0;
    checks++;
    if (instr !== NOP || instr_valid !== 1'b0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL flush_hold: instr=%h valid=%b pc=%h, required %h/0/00000000", instr, instr_valid, pc, NOP);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      failures++;
      $display("FAIL rvalid_idle: instr=%h valid=%b, required %h/0", instr, instr_valid, NOP);
    end
    $display("test_flush_hold: pc=%h", pc);
  endtask

  task automatic test_misalign();
    do_fetch(32'h0000_0005);
    do_commit(2'b01, 32'h0000_0102, 32'h0);
`ifdef RISCV_MISALIGN_TRAP_EN
    checks++;
    if (trap !== 1'b1 || pc !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL trap_pulse: trap=%b pc=%h valid=%b, required 1/00000000/0", trap, pc, instr_valid);
    end
    step();
    checks++;
    if (trap !== 1'b0) begin
      failures++;
      $display("FAIL trap_width: trap=%b, required 0", trap);
    end
`else
    checks++;
    if (trap !== 1'b0 || pc !== 32'h100 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_force: trap=%b pc=%h valid=%b, required 0/00000100/0", trap, pc, instr_valid);
    end
`endif
    $display("test_misalign: pc=%h trap=%b", pc, trap);
  endtask

  task automatic test_reset_in_req();
    fetch = 1'b1; step(); fetch = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_req: req=%b, required 1", imem_req);
    end
    #1 rst = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: req=%b pc=%h valid=%b, required 0/00000000/0", imem_req, pc, instr_valid);
    end
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D; step(); imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP) begin
      failures++;
      $display("FAIL post_reset_rvalid: instr=%h valid=%b, required %h/0", instr, instr_valid, NOP);
    end
    $display("test_reset_in_req: pc=%h", pc);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_pc_we_ignored();
    test_gnt_delay();
    test_pc_sel();
    test_flush_resp();
    test_flush_hold();
    test_misalign();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
